snn_input_sequencer: RTL and testbench
======================================

// Module: snn_input_sequencer
// PURPOSE
//  Upstream feeder for the SNN core. Buffers one pattern's Img/Kernel/Weight words and Opt from a
//  host valid/ready write port, then replays them onto the SNN input bus with the exact in_valid
//  timing. It then waits for the SNN out_valid pulse and returns the 32-bit result to the host over
//  a valid/ready response port. It also drives the SNN cg_en input for the duration of the pattern.
// PARAMETERS
//  IMG_LEN      72    Img words per pattern; also the snn_in_valid length in cycles
//  KER_LEN      27    Kernel words per pattern; must be <= IMG_LEN
//  WGT_LEN      4     Weight words per pattern; must be <= IMG_LEN
//  TIMEOUT_CYC  4096  WAIT-state watchdog limit in cycles; used only with SNN_SEQ_TIMEOUT_EN
// PORTS
//  clk            in   1   system clock, all flops rising-edge
//  rst_n          in   1   asynchronous active-low reset
//  wr_valid       in   1   host write word valid
//  wr_ready       out  1   host write word accepted when wr_valid & wr_ready
//  wr_sel         in   2   0=Img 1=Kernel 2=Weight 3=illegal
//  wr_data        in   32  IEEE-754 single-precision word
//  wr_opt         in   2   Opt value, captured with the first accepted Img word
//  cfg_cg_en      in   1   clock-gating request, captured at LOAD->ISSUE
//  snn_cg_en      out  1   to SNN cg_en, held from ISSUE entry until RESP exit
//  snn_in_valid   out  1   to SNN in_valid
//  snn_img        out  32  to SNN Img
//  snn_kernel     out  32  to SNN Kernel
//  snn_weight     out  32  to SNN Weight
//  snn_opt        out  2   to SNN Opt
//  snn_out_valid  in   1   from SNN out_valid
//  snn_out        in   32  from SNN out
//  res_valid      out  1   result valid to host
//  res_ready      in   1   host result accept
//  res_data       out  32  captured SNN result
//  res_err        out  1   qualifies res_data: 1 = timeout; tied 0 without the macro
//  busy           out  1   high in every state except LOAD
// BEHAVIOUR
//  - Reset: every output is 0 and wr_ready is 0 while rst_n is low. The FSM enters LOAD and all
//    counters clear. Reset mid-pattern aborts the pattern; no partial result is ever returned.
//  - FSM LOAD -> ISSUE -> WAIT -> RESP -> LOAD. All SNN-side outputs are registered.
//  - LOAD: separate counters for Img, Kernel and Weight fill register buffers in arrival order.
//    * wr_ready is 1 only if the selected stream is not full. Otherwise it is 0 and the host stalls.
//    * Words may interleave streams in any order.
//    * wr_sel=3: accepted (wr_ready=1) and discarded, with no state change.
//    * When all three streams are full, the next cycle enters ISSUE and wr_ready drops.
//  - ISSUE: lasts exactly IMG_LEN cycles; the cycle after the last load accept is the first.
//    * snn_in_valid=1 every ISSUE cycle; snn_img carries Img[k] on ISSUE cycle k.
//    * snn_kernel=Ker[k] for k<KER_LEN, else 0. snn_weight=Wgt[k] for k<WGT_LEN, else 0.
//    * snn_opt=Opt on k=0 only, else 0. All data outputs are 0 whenever snn_in_valid=0.
//  - WAIT: snn_in_valid=0.
//    * On the first cycle with snn_out_valid=1, capture snn_out into res_data and go to RESP.
//    * snn_out_valid seen in LOAD, ISSUE or RESP is ignored.
//  - RESP: res_valid=1 and res_data is held until res_ready=1.
//    * The handshake cycle returns to LOAD and clears res_valid, snn_cg_en and the counters.
//    * A new pattern's words are accepted from the following cycle.
//  - The buffers are not cleared between patterns; every slot is rewritten before the next ISSUE.
// CONFIGURATION
//  - Macro SNN_SEQ_TIMEOUT_EN defined:
//    * A WAIT-cycle counter runs during WAIT. On reaching TIMEOUT_CYC with no out_valid, the FSM
//      enters RESP with res_data=32'h7FC0_0000 (qNaN) and res_err=1.
//    * The counter clears on WAIT entry.
//  - Macro undefined: WAIT has no limit, res_err is constant 0, and the counter is not synthesized.
// TESTING
//  - Reset mid-ISSUE at k=10: all outputs 0 immediately. LOAD then accepts a full new pattern;
//    its ISSUE shows Img[0] on k=0.
//  - Load Img=k, Ker=100+k, Wgt=200+k, Opt=2 with all streams interleaved. Required:
//    * ISSUE starts 1 cycle after the last accept and lasts 72 cycles.
//    * snn_kernel=100..126 then 0; snn_weight=200..203 then 0; snn_opt=2 only on k=0.
//  - Send 5 Weight words: the 5th sees wr_ready=0 until the next LOAD. An illegal sel=3 word is
//    accepted and the stream counts are unchanged.
//  - snn_out_valid pulse with snn_out=32'h3F80_0000 three cycles into WAIT; res_ready held low
//    for 4 cycles. Required: res_data=32'h3F80_0000, res_valid stable until the handshake,
//    busy=0 the next cycle.
//  - snn_out_valid asserted during ISSUE: ignored; the later WAIT pulse is the returned result.
//  - With SNN_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, no out_valid: after 16 WAIT cycles res_valid=1,
//    res_err=1 and res_data=32'h7FC0_0000.

Source files
------------

// File: rtl/snn_input_sequencer.sv
// Host-to-SNN pattern sequencer: buffers one pattern, replays it on the SNN input bus, returns the result.
// Optional WAIT watchdog enabled by defining SNN_SEQ_TIMEOUT_EN.
module snn_input_sequencer #(
    parameter int unsigned IMG_LEN     = 72,
    parameter int unsigned KER_LEN     = 27,
    parameter int unsigned WGT_LEN     = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic [1:0]  wr_opt,
    input  logic        cfg_cg_en,
    output logic        snn_cg_en,
    output logic        snn_in_valid,
    output logic [31:0] snn_img,
    output logic [31:0] snn_kernel,
    output logic [31:0] snn_weight,
    output logic [1:0]  snn_opt,
    input  logic        snn_out_valid,
    input  logic [31:0] snn_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        busy
);

    localparam int unsigned IW = $clog2(IMG_LEN + 1);
    localparam int unsigned KW = $clog2(KER_LEN + 1);
    localparam int unsigned WW = $clog2(WGT_LEN + 1);

    if (KER_LEN > IMG_LEN || WGT_LEN > IMG_LEN || KER_LEN == 0 || WGT_LEN == 0 || TIMEOUT_CYC == 0) begin : g_param_check
        $error("snn_input_sequencer: illegal parameter set");
    end

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0] img_cnt, k_cnt, k_nxt;
    logic [KW-1:0] ker_cnt;
    logic [WW-1:0] wgt_cnt;
    logic [31:0]   img_buf [IMG_LEN];
    logic [31:0]   ker_buf [KER_LEN];
    logic [31:0]   wgt_buf [WGT_LEN];
    logic [1:0]    opt_reg;

    logic img_full, ker_full, wgt_full, sel_full;
    logic accept, acc_img, acc_ker, acc_wgt;
    logic load_done, issue_last, timeout;

    logic        in_valid_d, cg_d;
    logic [31:0] img_d, ker_d, wgt_d, res_d;
    logic [1:0]  opt_d;

    assign img_full = (img_cnt == IW'(IMG_LEN));
    assign ker_full = (ker_cnt == KW'(KER_LEN));
    assign wgt_full = (wgt_cnt == WW'(WGT_LEN));

    always_comb begin
        sel_full = 1'b0;
        case (wr_sel)
            2'd0:    sel_full = img_full;
            2'd1:    sel_full = ker_full;
            2'd2:    sel_full = wgt_full;
            default: sel_full = 1'b0;
        endcase
    end

    assign wr_ready = rst_n && (state == LOAD) && !sel_full;
    assign accept   = wr_valid && wr_ready;
    assign acc_img  = accept && (wr_sel == 2'd0);
    assign acc_ker  = accept && (wr_sel == 2'd1);
    assign acc_wgt  = accept && (wr_sel == 2'd2);

    // Look ahead so ISSUE starts on the cycle right after the final accept.
    assign load_done = (img_full || (acc_img && img_cnt == IW'(IMG_LEN - 1))) &&
                       (ker_full || (acc_ker && ker_cnt == KW'(KER_LEN - 1))) &&
                       (wgt_full || (acc_wgt && wgt_cnt == WW'(WGT_LEN - 1)));
    assign issue_last = (k_cnt == IW'(IMG_LEN - 1));

    assign busy      = (state != LOAD);
    assign res_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (load_done) state_nxt = ISSUE;
            ISSUE:   if (issue_last) state_nxt = WAIT;
            WAIT:    if (snn_out_valid || timeout) state_nxt = RESP;
            RESP:    if (res_ready) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_cnt <= '0;
            ker_cnt <= '0;
            wgt_cnt <= '0;
            k_cnt   <= '0;
            opt_reg <= '0;
        end else begin
            if (state == RESP && res_ready) begin
                img_cnt <= '0;
                ker_cnt <= '0;
                wgt_cnt <= '0;
            end else begin
                if (acc_img) img_cnt <= img_cnt + IW'(1);
                if (acc_ker) ker_cnt <= ker_cnt + KW'(1);
                if (acc_wgt) wgt_cnt <= wgt_cnt + WW'(1);
            end
            if (acc_img && img_cnt == '0) opt_reg <= wr_opt;
            k_cnt <= (state == ISSUE) ? k_cnt + IW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < IMG_LEN; i++)
            if (acc_img && img_cnt == IW'(i)) img_buf[i] <= wr_data;
        for (int unsigned i = 0; i < KER_LEN; i++)
            if (acc_ker && ker_cnt == KW'(i)) ker_buf[i] <= wr_data;
        for (int unsigned i = 0; i < WGT_LEN; i++)
            if (acc_wgt && wgt_cnt == WW'(i)) wgt_buf[i] <= wr_data;
    end

    always_comb begin
        k_nxt      = (state == ISSUE) ? k_cnt + IW'(1) : '0;
        in_valid_d = 1'b0;
        img_d      = '0;
        ker_d      = '0;
        wgt_d      = '0;
        opt_d      = '0;
        if (state_nxt == ISSUE) begin
            in_valid_d = 1'b1;
            for (int unsigned i = 0; i < IMG_LEN; i++)
                if (k_nxt == IW'(i)) img_d = img_buf[i];
            for (int unsigned i = 0; i < KER_LEN; i++)
                if (k_nxt == IW'(i)) ker_d = ker_buf[i];
            for (int unsigned i = 0; i < WGT_LEN; i++)
                if (k_nxt == IW'(i)) wgt_d = wgt_buf[i];
            if (k_nxt == '0) begin
                opt_d = opt_reg;
                // Slot 0 of a length-1 stream can be written by the very accept that starts ISSUE.
                if (acc_img && img_cnt == '0) begin
                    img_d = wr_data;
                    opt_d = wr_opt;
                end
                if (acc_ker && ker_cnt == '0) ker_d = wr_data;
                if (acc_wgt && wgt_cnt == '0) wgt_d = wr_data;
            end
        end

        cg_d = snn_cg_en;
        if (state == LOAD && state_nxt == ISSUE)     cg_d = cfg_cg_en;
        else if (state == RESP && state_nxt == LOAD) cg_d = 1'b0;

        res_d = res_data;
        if (state == WAIT) begin
            if (snn_out_valid) res_d = snn_out;
            else if (timeout)  res_d = 32'h7FC0_0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snn_in_valid <= 1'b0;
            snn_img      <= '0;
            snn_kernel   <= '0;
            snn_weight   <= '0;
            snn_opt      <= '0;
            snn_cg_en    <= 1'b0;
            res_data     <= '0;
        end else begin
            snn_in_valid <= in_valid_d;
            snn_img      <= img_d;
            snn_kernel   <= ker_d;
            snn_weight   <= wgt_d;
            snn_opt      <= opt_d;
            snn_cg_en    <= cg_d;
            res_data     <= res_d;
        end
    end

`ifdef SNN_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              wait_cnt <= '0;
        else if (state != WAIT)  wait_cnt <= '0;
        else                     wait_cnt <= wait_cnt + TW'(1);
    end

    assign timeout = (state == WAIT) && !snn_out_valid && (wait_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 res_err <= 1'b0;
        else if (state == WAIT && snn_out_valid)    res_err <= 1'b0;
        else if (timeout)                           res_err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_snn_input_sequencer.sv
// Scoreboard bench for snn_input_sequencer: expected beats/results queued at stimulus time, popped by a monitor.
module tb_snn_input_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_sel = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  wr_opt = '0;
    logic        cfg_cg_en = 1'b0;
    logic        snn_cg_en;
    logic        snn_in_valid;
    logic [31:0] snn_img, snn_kernel, snn_weight;
    logic [1:0]  snn_opt;
    logic        snn_out_valid = 1'b0;
    logic [31:0] snn_out = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_err;
    logic        busy;

    always #5 clk = ~clk;

    snn_input_sequencer #(
        .IMG_LEN(72),
        .KER_LEN(27),
        .WGT_LEN(4),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data), .wr_opt(wr_opt),
        .cfg_cg_en(cfg_cg_en), .snn_cg_en(snn_cg_en),
        .snn_in_valid(snn_in_valid), .snn_img(snn_img), .snn_kernel(snn_kernel),
        .snn_weight(snn_weight), .snn_opt(snn_opt),
        .snn_out_valid(snn_out_valid), .snn_out(snn_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .busy(busy)
    );

    typedef struct packed {
        logic [31:0] img;
        logic [31:0] ker;
        logic [31:0] wgt;
        logic [1:0]  opt;
    } beat_t;

    beat_t       beat_q[$];
    logic [32:0] res_q[$];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: pops expected beats on every in_valid cycle and expected results on every handshake.
    always @(negedge clk) begin
        beat_t       e;
        logic [32:0] r;
        if (snn_in_valid) begin
            if (beat_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL beat_unexpected: got img %h expected no beat", snn_img);
            end else begin
                e = beat_q.pop_front();
                check("beat_img", snn_img, e.img);
                check("beat_kernel", snn_kernel, e.ker);
                check("beat_weight", snn_weight, e.wgt);
                check("beat_opt", 32'(snn_opt), 32'(e.opt));
            end
        end else if (rst_n) begin
            check("idle_data_zero", snn_img | snn_kernel | snn_weight | 32'(snn_opt), 32'd0);
        end
        if (res_valid && res_ready) begin
            if (res_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL res_unexpected: got %h expected no result", res_data);
            end else begin
                r = res_q.pop_front();
                check("res_data", res_data, r[31:0]);
                check1("res_err", res_err, r[32]);
            end
        end
    end

    task automatic put(input logic [1:0] sel, input logic [31:0] d, input logic [1:0] opt);
        bit rdy = 1'b0;
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_data  = d;
        wr_opt   = opt;
        for (int c = 0; c < 50 && !rdy; c++) begin
            @(negedge clk);
            rdy = wr_ready;
            @(posedge clk);
            #1;
        end
        if (!rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL put_timeout: wr_ready stayed 0 expected 1 (sel %0d)", sel);
        end
        wr_valid = 1'b0;
    endtask

    task automatic load_pattern(input int unsigned ib, input int unsigned kb, input int unsigned wb,
                                input logic [1:0] opt, input bit ilv, input int unsigned n_beats);
        beat_t b;
        for (int unsigned k = 0; k < n_beats; k++) begin
            b.img = ib + k;
            b.ker = (k < 27) ? kb + k : 32'd0;
            b.wgt = (k < 4) ? wb + k : 32'd0;
            b.opt = (k == 0) ? opt : 2'd0;
            beat_q.push_back(b);
        end
        if (ilv) begin
            for (int unsigned i = 0; i < 72; i++) begin
                put(2'd0, ib + i, (i == 0) ? opt : ~opt);
                if (i < 27) put(2'd1, kb + i, ~opt);
                if (i < 4)  put(2'd2, wb + i, ~opt);
                if (i == 10) begin
                    wr_valid = 1'b1;
                    wr_sel   = 2'd2;
                    wr_data  = 32'hFFFF_0005;
                    repeat (3) begin
                        @(negedge clk);
                        check1("wgt5_stall", wr_ready, 1'b0);
                        @(posedge clk);
                        #1;
                    end
                    wr_sel  = 2'd3;
                    wr_data = 32'hBAD0_0003;
                    @(negedge clk);
                    check1("illegal_ready", wr_ready, 1'b1);
                    @(posedge clk);
                    #1;
                    wr_valid = 1'b0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < 72; i++) put(2'd0, ib + i, (i == 0) ? opt : ~opt);
            for (int unsigned i = 0; i < 27; i++) put(2'd1, kb + i, ~opt);
            for (int unsigned i = 0; i < 4; i++)  put(2'd2, wb + i, ~opt);
        end
    endtask

    task automatic issue_len(input logic exp_cg, output int len);
        len = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!snn_in_valid) break;
            len++;
            if (len == 1) begin
                check1("issue_busy", busy, 1'b1);
                check1("issue_wr_ready", wr_ready, 1'b0);
                check1("issue_cg_en", snn_cg_en, exp_cg);
            end
            @(posedge clk);
            #1;
            snn_out_valid = 1'b0;
            snn_out       = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int wc;

        // Reset state with a write pending
        wr_valid  = 1'b1;
        wr_sel    = 2'd0;
        cfg_cg_en = 1'b1;
        @(negedge clk);
        check1("rst_wr_ready", wr_ready, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_in_valid", snn_in_valid, 1'b0);
        check1("rst_res_valid", res_valid, 1'b0);
        check1("rst_cg_en", snn_cg_en, 1'b0);
        check("rst_res_data", res_data, 32'd0);
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pattern A: interleaved load, out_valid during ISSUE ignored, result 3 cycles into WAIT
        cfg_cg_en = 1'b1;
        load_pattern(0, 100, 200, 2'd2, 1'b1, 72);
        snn_out_valid = 1'b1;
        snn_out       = 32'hDEAD_BEEF;
        issue_len(1'b1, len);
        check("issue_len_a", len, 32'd72);
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        snn_out_valid = 1'b1;
        snn_out       = 32'h3F80_0000;
        res_q.push_back({1'b0, 32'h3F80_0000});
        @(posedge clk);
        #1;
        snn_out_valid = 1'b0;
        snn_out       = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check1("resp_valid_hold", res_valid, 1'b1);
            check("resp_data_hold", res_data, 32'h3F80_0000);
            check1("resp_err", res_err, 1'b0);
            check1("resp_cg_en", snn_cg_en, 1'b1);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check1("post_busy", busy, 1'b0);
        check1("post_res_valid", res_valid, 1'b0);
        check1("post_cg_en", snn_cg_en, 1'b0);
        check1("post_wr_ready", wr_ready, 1'b1);
        @(posedge clk);
        #1;

        // Pattern B: reset at ISSUE k=10
        cfg_cg_en = 1'b1;
        load_pattern(1000, 1100, 1200, 2'd1, 1'b0, 10);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check1("abort_in_valid", snn_in_valid, 1'b0);
        check("abort_img", snn_img, 32'd0);
        check("abort_kernel", snn_kernel, 32'd0);
        check("abort_weight", snn_weight, 32'd0);
        check("abort_opt", 32'(snn_opt), 32'd0);
        check1("abort_cg_en", snn_cg_en, 1'b0);
        check1("abort_busy", busy, 1'b0);
        check1("abort_res_valid", res_valid, 1'b0);
        check("abort_res_data", res_data, 32'd0);
        check1("abort_wr_ready", wr_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pattern C: full reload after abort, result on WAIT cycle 1 with res_ready already high
        cfg_cg_en = 1'b0;
        res_ready = 1'b1;
        load_pattern(500, 600, 700, 2'd3, 1'b0, 72);
        issue_len(1'b0, len);
        check("issue_len_c", len, 32'd72);
        @(posedge clk);
        #1;
        snn_out_valid = 1'b1;
        snn_out       = 32'h4000_0000;
        res_q.push_back({1'b0, 32'h4000_0000});
        @(posedge clk);
        #1;
        snn_out_valid = 1'b0;
        snn_out       = '0;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check1("c_post_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // Pattern D: WAIT with no out_valid
        load_pattern(2000, 2100, 2200, 2'd0, 1'b0, 72);
        issue_len(1'b0, len);
        check("issue_len_d", len, 32'd72);
`ifdef SNN_SEQ_TIMEOUT_EN
        res_q.push_back({1'b1, 32'h7FC0_0000});
        wc = 1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (res_valid) break;
            wc++;
        end
        check("timeout_wait_cycles", wc, 32'd16);
        check1("timeout_res_valid", res_valid, 1'b1);
        check1("timeout_res_err", res_err, 1'b1);
        check("timeout_res_data", res_data, 32'h7FC0_0000);
`else
        wc = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (res_valid) wc++;
        end
        check("no_timeout_res_valid", wc, 32'd0);
        @(posedge clk);
        #1;
        snn_out_valid = 1'b1;
        snn_out       = 32'hC000_0000;
        res_q.push_back({1'b0, 32'hC000_0000});
        @(posedge clk);
        #1;
        snn_out_valid = 1'b0;
        snn_out       = '0;
        @(negedge clk);
        check1("late_res_valid", res_valid, 1'b1);
        check1("late_res_err", res_err, 1'b0);
`endif
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check1("d_post_busy", busy, 1'b0);

        repeat (3) @(posedge clk);
        check("beat_q_drained", beat_q.size(), 32'd0);
        check("res_q_drained", res_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
